muldiv_unit: RTL

- Multi-cycle arithmetic responder on the control unit's stall/ALU_ready handshake. Executes MUL (0x11), DIV (0x12) and MOD (0x13) while the control unit holds `stall`.
- Sits beside the single-cycle ALU. Drives the shared result/flags mux while its ops run.
- Iterative: shift-add multiply, restoring divide. Unsigned operands only.

---
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned MUL / DIV / MOD responder that sits beside
// the single-cycle ALU. It runs while the control unit holds `stall` (start).
// When it finishes, it pulses ALU_ready for one cycle.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               level request (control unit stall), held while pending
//   opcode              6'h11 MUL, 6'h12 DIV, 6'h13 MOD; any other value
//                       returns zero with Z set
//   x, y                operands (multiplicand/dividend, multiplier/divisor)
//   ALU_ready           one-cycle completion pulse (DONE state)
//   busy                high in RUN and DONE
//   result, result_hi   low word / quotient / remainder, and MUL high word
//   flags               [0]=Z [1]=N [2]=C [3]=V
//
// Optional build macro MULDIV_EARLY_EXIT_EN: MUL leaves RUN once the remaining
// multiplier bits are zero. The results are the same either way.
module muldiv_unit #(
  parameter int         WIDTH  = 16,
  parameter logic [5:0] OP_MUL = 6'h11,
  parameter logic [5:0] OP_DIV = 6'h12,
  parameter logic [5:0] OP_MOD = 6'h13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ALU_ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [5:0]         op_q, op_nxt;
  logic [WIDTH-1:0]   b_q, b_nxt;          // multiplicand (MUL) or divisor (DIV/MOD)
  logic [2*WIDTH-1:0] acc, acc_nxt;        // MUL {hi, lo/multiplier}; DIV {rem, quot}

  logic               res_ld;
  logic [WIDTH-1:0]   res_nxt, res_hi_nxt;
  logic [3:0]         flags_nxt;

  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] acc_step, fin;
  logic               last;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0]   rem_mask;
`endif

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    return {v, c, r[WIDTH-1], (r == '0)};
  endfunction

  // One iteration of the selected algorithm.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    // The remainder is always below the divisor, so bit WIDTH of the
    // difference is a reliable borrow (negative) indicator.
    div_diff = div_sh - {1'b0, b_q};
    acc_step = acc;
    if (op_q == OP_MUL) begin
      if (acc[0]) acc_step = {mul_sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_step = {div_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_nxt     = op_q;
    b_nxt      = b_q;
    acc_nxt    = acc;
    res_ld     = 1'b0;
    res_nxt    = '0;
    res_hi_nxt = '0;
    flags_nxt  = '0;
    fin        = acc_step;
    last       = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
    rem_mask   = '0;
`endif
    case (state)
      IDLE: if (start) begin
        op_nxt  = opcode;
        cnt_nxt = CW'(WIDTH);
        if (opcode == OP_MUL) begin
          b_nxt     = x;
          acc_nxt   = {{WIDTH{1'b0}}, y};
          state_nxt = RUN;
        end else if (opcode == OP_DIV || opcode == OP_MOD) begin
          b_nxt   = y;
          acc_nxt = {{WIDTH{1'b0}}, x};
          if (y == '0) begin
            // Divide by zero: all-ones quotient, remainder is the dividend.
            res_ld    = 1'b1;
            res_nxt   = (opcode == OP_DIV) ? '1 : x;
            flags_nxt = mk_flags(res_nxt, 1'b0, 1'b1);
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          res_ld    = 1'b1;
          flags_nxt = 4'b0001;
          state_nxt = DONE;
        end
      end
      RUN: if (!start) begin
        state_nxt = IDLE;                 // abort: outputs untouched
      end else begin
        acc_nxt = acc_step;
        cnt_nxt = cnt - CW'(1);
        last    = (cnt == CW'(1));
`ifdef MULDIV_EARLY_EXIT_EN
        // Unprocessed multiplier bits are the low (cnt-1) bits of the low word.
        // Once they are all zero, only right shifts remain, so those shifts
        // are applied in a single step.
        rem_mask = (WIDTH'(1) << (cnt - CW'(1))) - WIDTH'(1);
        if (op_q == OP_MUL && (acc_step[WIDTH-1:0] & rem_mask) == '0) begin
          fin  = acc_step >> (cnt - CW'(1));
          last = 1'b1;
        end
`endif
        if (last) begin
          res_ld    = 1'b1;
          state_nxt = DONE;
          if (op_q == OP_MUL) begin
            res_nxt    = fin[WIDTH-1:0];
            res_hi_nxt = fin[2*WIDTH-1:WIDTH];
            flags_nxt  = mk_flags(res_nxt, (res_hi_nxt != '0), 1'b0);
          end else if (op_q == OP_DIV) begin
            res_nxt   = fin[WIDTH-1:0];
            flags_nxt = mk_flags(res_nxt, 1'b0, 1'b0);
          end else begin
            res_nxt   = fin[2*WIDTH-1:WIDTH];
            flags_nxt = mk_flags(res_nxt, 1'b0, 1'b0);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      b_q       <= '0;
      acc       <= '0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
      b_q   <= b_nxt;
      acc   <= acc_nxt;
      if (res_ld) begin
        result    <= res_nxt;
        result_hi <= res_hi_nxt;
        flags     <= flags_nxt;
      end
    end
  end

  assign ALU_ready = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
